// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared defaults and types for the spectrum ping-pong buffer
package mfcc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_BINS   = 257;

  typedef logic bank_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } rd_state_e;

endpackage

// File: rtl/spectrum_bank_ram.sv
// rtl/spectrum_bank_ram.sv - two-bank simple dual-port RAM, bank select is the address MSB
module spectrum_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BINS   = 257,
  localparam int ADDR_WIDTH = $clog2(NUM_BINS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2][NUM_BINS];

  // rd_data only updates on rd_en, so it doubles as the held output beat
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr[ADDR_WIDTH]][wr_addr[ADDR_WIDTH-1:0]] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr[ADDR_WIDTH]][rd_addr[ADDR_WIDTH-1:0]];
  end

endmodule

// File: rtl/spectrum_pingpong_buffer.sv
// rtl/spectrum_pingpong_buffer.sv - double-buffered power-spectrum capture and in-order streaming
// Optional peak tracker ports/logic enabled by SPECTRUM_PEAK_EN.
module spectrum_pingpong_buffer
  import mfcc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_BINS   = DEFAULT_NUM_BINS,
  localparam int ADDR_WIDTH = $clog2(NUM_BINS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_ptr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  frame_done_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic                  rd_last_o,
  output logic                  frame_avail_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_count_o
`ifdef SPECTRUM_PEAK_EN
  ,
  output logic                  peak_valid_o,
  output logic [ADDR_WIDTH-1:0] peak_bin_o,
  output logic [DATA_WIDTH-1:0] peak_value_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

  rd_state_e             state, state_n;
  bank_idx_t             wr_bank, rd_bank, rd_bank_n;
  logic [1:0]            full, full_n;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_n, ram_rd_ptr;
  logic                  ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  wr_en, at_last, release_bank, tgt_full, commit_ok, commit_drop;

  // A full bank is never written, so a held-off frame cannot corrupt one awaiting readout
  assign wr_en        = wr_valid_i && (wr_ptr_i <= LAST_BIN) && !full[wr_bank];
  assign at_last      = (state == STREAM) && (rd_ptr == LAST_BIN);
  assign release_bank = at_last && rd_ready_i;
  assign tgt_full     = full[wr_bank] && !(release_bank && (rd_bank == wr_bank));
  assign commit_ok    = frame_done_i && !tgt_full;
  assign commit_drop  = frame_done_i && tgt_full;

  always_comb begin
    full_n = full;
    if (release_bank) full_n[rd_bank] = 1'b0;
    if (commit_ok)    full_n[wr_bank] = 1'b1;
  end

  // Banks are committed and drained in strict alternation, so rd_bank is always the oldest
  always_comb begin
    state_n    = state;
    rd_bank_n  = rd_bank;
    rd_ptr_n   = rd_ptr;
    ram_rd_en  = 1'b0;
    ram_rd_ptr = rd_ptr + 1'b1;
    case (state)
      IDLE: begin
        if (full_n[rd_bank]) state_n = FETCH;
      end
      FETCH: begin
        ram_rd_en  = 1'b1;
        ram_rd_ptr = '0;
        rd_ptr_n   = '0;
        state_n    = STREAM;
      end
      STREAM: begin
        if (rd_ready_i) begin
          if (rd_ptr == LAST_BIN) begin
            rd_bank_n = ~rd_bank;
            state_n   = full_n[~rd_bank] ? FETCH : IDLE;
          end else begin
            ram_rd_en = 1'b1;
            rd_ptr_n  = rd_ptr + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_bank       <= 1'b0;
      rd_ptr        <= '0;
      wr_bank       <= 1'b0;
      full          <= 2'b00;
      frame_avail_o <= 1'b0;
      overflow_o    <= 1'b0;
      drop_count_o  <= '0;
    end else begin
      state         <= state_n;
      rd_bank       <= rd_bank_n;
      rd_ptr        <= rd_ptr_n;
      full          <= full_n;
      frame_avail_o <= |full_n;
      overflow_o    <= commit_drop;
      if (commit_ok) wr_bank <= ~wr_bank;
      if (commit_drop && (drop_count_o != 16'hFFFF))
        drop_count_o <= drop_count_o + 16'd1;
    end
  end

  assign rd_valid_o = (state == STREAM);
  assign rd_data_o  = rd_valid_o ? ram_rd_data : '0;
  assign rd_ptr_o   = rd_valid_o ? rd_ptr : '0;
  assign rd_last_o  = at_last;

  spectrum_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BINS   (NUM_BINS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_ptr_i}),
    .wr_data (wr_data_i),
    .rd_en   (ram_rd_en),
    .rd_addr ({rd_bank, ram_rd_ptr}),
    .rd_data (ram_rd_data)
  );

`ifdef SPECTRUM_PEAK_EN
  logic                  pk_seen, pk_take;
  logic [ADDR_WIDTH-1:0] pk_bin, cur_bin;
  logic [DATA_WIDTH-1:0] pk_val, cur_val;

  // Ties keep the lower bin; a same-cycle write is part of the committed frame
  always_comb begin
    pk_take = wr_en && (!pk_seen || (wr_data_i > pk_val) ||
                        ((wr_data_i == pk_val) && (wr_ptr_i < pk_bin)));
    cur_bin = pk_take ? wr_ptr_i  : pk_bin;
    cur_val = pk_take ? wr_data_i : pk_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_seen      <= 1'b0;
      pk_bin       <= '0;
      pk_val       <= '0;
      peak_valid_o <= 1'b0;
      peak_bin_o   <= '0;
      peak_value_o <= '0;
    end else begin
      peak_valid_o <= commit_ok;
      if (commit_ok) begin
        peak_bin_o   <= cur_bin;
        peak_value_o <= cur_val;
      end
      if (frame_done_i) begin
        pk_seen <= 1'b0;
      end else if (pk_take) begin
        pk_seen <= 1'b1;
        pk_bin  <= wr_ptr_i;
        pk_val  <= wr_data_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spectrum_pingpong_buffer.sv
// tb/tb_spectrum_pingpong_buffer.sv - directed self-checking bench for spectrum_pingpong_buffer
module tb_spectrum_pingpong_buffer;

  localparam int NB = 257;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid_i, frame_done_i, rd_ready_i;
  logic [AW-1:0] wr_ptr_i;
  logic [31:0]   wr_data_i;
  logic          rd_valid_o, rd_last_o, frame_avail_o, overflow_o;
  logic [31:0]   rd_data_o;
  logic [AW-1:0] rd_ptr_o;
  logic [15:0]   drop_count_o;
`ifdef SPECTRUM_PEAK_EN
  logic          peak_valid_o;
  logic [AW-1:0] peak_bin_o;
  logic [31:0]   peak_value_o;
`endif

  int n_pass = 0;
  int n_total = 0;
  int ovf_pulses = 0;

  spectrum_pingpong_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid_i    (wr_valid_i),
    .wr_ptr_i      (wr_ptr_i),
    .wr_data_i     (wr_data_i),
    .frame_done_i  (frame_done_i),
    .rd_ready_i    (rd_ready_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_ptr_o      (rd_ptr_o),
    .rd_last_o     (rd_last_o),
    .frame_avail_o (frame_avail_o),
    .overflow_o    (overflow_o),
    .drop_count_o  (drop_count_o)
`ifdef SPECTRUM_PEAK_EN
    ,
    .peak_valid_o  (peak_valid_o),
    .peak_bin_o    (peak_bin_o),
    .peak_value_o  (peak_value_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow_o === 1'b1) ovf_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, rd_valid_o, 0);
    chk({tag, "_data"}, rd_data_o, 0);
    chk({tag, "_ptr"}, rd_ptr_o, 0);
    chk({tag, "_last"}, rd_last_o, 0);
    chk({tag, "_avail"}, frame_avail_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_drops"}, drop_count_o, 0);
  endtask

  task automatic write_frame(input logic [31:0] base, input logic [31:0] mult);
    for (int b = 0; b < NB; b++) begin
      wr_valid_i   = 1'b1;
      wr_ptr_i     = AW'(b);
      wr_data_i    = base + b * mult;
      frame_done_i = (b == NB - 1);
      step();
    end
    wr_valid_i   = 1'b0;
    frame_done_i = 1'b0;
  endtask

  // Checks every valid cycle (stalled or not) against the beat the bench expects next
  task automatic read_frame(input string tag, input logic [31:0] base, input logic [31:0] mult,
                            input bit toggle, input int limit, output int wait_cyc);
    int idx = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] exp_v;
    wait_cyc = 0;
    while (rd_valid_o !== 1'b1 && wait_cyc < 20) begin
      rd_ready_i = 1'b1;
      step();
      wait_cyc++;
    end
    chk({tag, "_start"}, rd_valid_o, 1);
    while (idx < limit && cyc < 2000) begin
      rd_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rd_valid_o === 1'b1) begin
        exp_v = base + idx * mult;
        if (rd_data_o !== exp_v || rd_ptr_o !== AW'(idx) || rd_last_o !== (idx == NB - 1))
          bad++;
        if (rd_ready_i) idx++;
      end else begin
        bad++;
      end
      step();
      cyc++;
    end
    rd_ready_i = 1'b0;
    chk({tag, "_beats"}, bad, 0);
    chk({tag, "_count"}, idx, limit);
  endtask

  initial begin
    int w, wa, vcount, ovf_base;
    rst_n = 1'b0;
    wr_valid_i = 1'b0; wr_ptr_i = '0; wr_data_i = '0; frame_done_i = 1'b0; rd_ready_i = 1'b0;
    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    // single frame, ready held high
    write_frame(32'd0, 32'd3);
    chk("sf_avail", frame_avail_o, 1);
    read_frame("sf", 32'd0, 32'd3, 1'b0, NB, w);
    chk("sf_latency", w, 1);
    chk("sf_valid_after", rd_valid_o, 0);
    chk("sf_avail_after", frame_avail_o, 0);

    // back-pressure with ready toggling every cycle
    write_frame(32'h500, 32'd2);
    read_frame("bp", 32'h500, 32'd2, 1'b1, NB, w);
    chk("bp_avail_after", frame_avail_o, 0);

    // ping-pong: B fills and commits while A streams
    ovf_base = ovf_pulses;
    write_frame(32'h1000, 32'd1);
    fork
      write_frame(32'h2000, 32'd1);
      read_frame("pp_a", 32'h1000, 32'd1, 1'b0, NB, wa);
    join
    read_frame("pp_b", 32'h2000, 32'd1, 1'b0, NB, w);
    chk("pp_gap", w, 1);
    chk("pp_no_ovf", ovf_pulses - ovf_base, 0);

    // overflow: A and B held by back-pressure, C is dropped
    ovf_base = ovf_pulses;
    rd_ready_i = 1'b0;
    write_frame(32'h3000, 32'd1);
    write_frame(32'h4000, 32'd1);
    write_frame(32'h5000, 32'd1);
    chk("ovf_pulse", overflow_o, 1);
    chk("ovf_drops", drop_count_o, 1);
    step();
    chk("ovf_pulse_end", overflow_o, 0);
    read_frame("ovf_a", 32'h3000, 32'd1, 1'b0, NB, w);
    read_frame("ovf_b", 32'h4000, 32'd1, 1'b0, NB, w);
    chk("ovf_b_gap", w, 1);
    vcount = 0;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rd_valid_o === 1'b1) vcount++;
      step();
    end
    chk("ovf_no_c", vcount, 0);
    chk("ovf_pulse_count", ovf_pulses - ovf_base, 1);
    chk("ovf_avail_after", frame_avail_o, 0);

    // stray write beyond the last bin is ignored
    wr_valid_i = 1'b1; wr_ptr_i = 9'd300; wr_data_i = 32'hDEAD;
    step();
    write_frame(32'h8000, 32'd1);
    read_frame("bnd", 32'h8000, 32'd1, 1'b0, NB, w);

    // reset asserted while bin 100 is presented
    write_frame(32'h6000, 32'd1);
    read_frame("rst", 32'h6000, 32'd1, 1'b0, 100, w);
    chk("rst_pre_ptr", rd_ptr_o, 100);
    chk("rst_pre_drops", drop_count_o, 1);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    step();
    rst_n = 1'b1;
    vcount = 0;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid_o === 1'b1 || frame_avail_o === 1'b1) vcount++;
      step();
    end
    chk("rst_quiet", vcount, 0);
    write_frame(32'h7000, 32'd5);
    read_frame("rec", 32'h7000, 32'd5, 1'b0, NB, w);
    chk("rec_latency", w, 1);

`ifdef SPECTRUM_PEAK_EN
    for (int b = 0; b < NB; b++) begin
      wr_valid_i   = 1'b1;
      wr_ptr_i     = AW'(b);
      wr_data_i    = (b == 40 || b == 90) ? 32'd500 : 32'd0;
      frame_done_i = (b == NB - 1);
      step();
    end
    wr_valid_i = 1'b0; frame_done_i = 1'b0;
    chk("pk_valid", peak_valid_o, 1);
    chk("pk_bin", peak_bin_o, 40);
    chk("pk_value", peak_value_o, 500);
    step();
    chk("pk_valid_end", peak_valid_o, 0);
    rd_ready_i = 1'b1;
    repeat (300) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
